// File: rtl/alu_seq_ctrl_if.sv
// Host-side bus for alu_seq_ctrl: instruction handshake
// plus register-file load port.
interface alu_seq_ctrl_if;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready,
    output ld_en,
    output ld_addr,
    output ld_data
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready,
    input  ld_en,
    input  ld_addr,
    input  ld_data
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Four-state sequencer driving an external 8-bit ALU
// from a 4 x 8 register file (IDLE/READ/EXEC/WRITE).
module alu_seq_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  alu_seq_ctrl_if.slave        bus,
  output logic [7:0]           alu_op1,
  output logic [7:0]           alu_op2,
  output logic [2:0]           alu_sel,
  input  logic [7:0]           alu_out,
  input  logic                 alu_co,
  output logic                 done,
  output logic [7:0]           result,
  output logic                 carry,
  output logic                 busy,
  output logic [7:0]           instr_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  state_t     state;
  logic [7:0] rf [4];
  logic [8:0] ir;
  logic [7:0] cap_res;
  logic       cap_co;
  logic [7:0] last_res;

  assign bus.instr_ready = (state == IDLE) && !rst;
  assign busy = (state != IDLE);
  // result tracks the captured value while done, else the last write-back
  assign result = done ? cap_res : last_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) rf[i] <= '0;
      ir        <= '0;
      alu_op1   <= '0;
      alu_op2   <= '0;
      alu_sel   <= '0;
      cap_res   <= '0;
      cap_co    <= 1'b0;
      last_res  <= '0;
      carry     <= 1'b0;
      instr_cnt <= '0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_en)
            rf[bus.ld_addr] <= bus.ld_data;
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= READ;
          end
        end
        READ: begin
          alu_op1 <= rf[ir[3:2]];
          alu_op2 <= rf[ir[1:0]];
          alu_sel <= ir[8:6];
          state   <= EXEC;
        end
        EXEC: begin
          cap_res <= alu_out;
          cap_co  <= alu_co;
          done    <= 1'b1;
          state   <= WRITE;
        end
        WRITE: begin
          rf[ir[5:4]] <= cap_res;
          last_res    <= cap_res;
          carry       <= cap_co;
          instr_cnt   <= instr_cnt + 8'd1;
          done        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a behavioural
// ALU and register-file reference model.
module tb_alu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_op1, alu_op2, alu_out;
  logic [2:0] alu_sel;
  logic       alu_co;
  logic       done, carry, busy;
  logic [7:0] result, instr_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_rf [4];
  logic [7:0] m_cnt;
  logic       m_carry;
  logic [7:0] m_res;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_op1   (alu_op1),
    .alu_op2   (alu_op2),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .alu_co    (alu_co),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .busy      (busy),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {(a < b), 8'(a - b)};
      3'd2:    return {1'b0, ~(a ^ b)};
      3'd3:    return {1'b0, a & b};
      3'd4:    return {1'b0, a};
      3'd5:    return {1'b0, b};
      3'd6:    return {1'b0, a | b};
      default: return {1'b0, a};
    endcase
  endfunction

  always_comb {alu_co, alu_out} = alu_fn(alu_sel, alu_op1, alu_op2);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    m_cnt   = '0;
    m_carry = 1'b0;
    m_res   = '0;
  endtask

  task automatic load(input logic [1:0] a, input logic [7:0] d);
    bus.ld_en   = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
    step();
    bus.ld_en = 1'b0;
    m_rf[a] = d;
  endtask

  task automatic run_instr(
    input logic [2:0] op,
    input logic [1:0] rd,
    input logic [1:0] rs1,
    input logic [1:0] rs2,
    input logic       lde,
    input logic [1:0] la,
    input logic [7:0] lv
  );
    logic [8:0] r;
    logic [7:0] a, b;
    chk("ready_idle", 32'(bus.instr_ready), 1);
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, rs1, rs2};
    bus.ld_en       = lde;
    bus.ld_addr     = la;
    bus.ld_data     = lv;
    step();
    bus.instr_valid = 1'b0;
    bus.ld_en       = 1'b0;
    if (lde) m_rf[la] = lv;
    a = m_rf[rs1];
    b = m_rf[rs2];
    r = alu_fn(op, a, b);
    chk("busy_read", 32'(busy), 1);
    chk("ready_read", 32'(bus.instr_ready), 0);
    chk("done_read", 32'(done), 0);
    step();
    chk("op1", 32'(alu_op1), 32'(a));
    chk("op2", 32'(alu_op2), 32'(b));
    chk("sel", 32'(alu_sel), 32'(op));
    chk("done_exec", 32'(done), 0);
    step();
    chk("done_write", 32'(done), 1);
    chk("result_write", 32'(result), 32'(r[7:0]));
    step();
    m_rf[rd] = r[7:0];
    m_cnt    = m_cnt + 8'd1;
    m_carry  = r[8];
    m_res    = r[7:0];
    chk("done_idle", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("result_held", 32'(result), 32'(m_res));
    chk("carry", 32'(carry), 32'(m_carry));
    chk("instr_cnt", 32'(instr_cnt), 32'(m_cnt));
  endtask

  initial begin
    int lowc;
    int dcount;
    int wide;
    logic pd;

    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ld_en       = 1'b0;
    bus.ld_addr     = '0;
    bus.ld_data     = '0;
    step();
    step();
    chk("rst_ready", 32'(bus.instr_ready), 0);
    chk("rst_op1", 32'(alu_op1), 0);
    chk("rst_op2", 32'(alu_op2), 0);
    chk("rst_sel", 32'(alu_sel), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_cnt", 32'(instr_cnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    do_reset();
    chk("ready_after_rst", 32'(bus.instr_ready), 1);

    // ADD 0x80 + 0x80 -> 0x00 with carry
    load(2'd0, 8'h80);
    load(2'd1, 8'h80);
    run_instr(3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00);
    chk("add_res", 32'(m_res), 32'h00);
    chk("add_carry", 32'(carry), 1);
    run_instr(3'd4, 2'd3, 2'd2, 2'd2, 1'b0, 2'd0, 8'h00);

    // XNOR with rd == rs1, then read back R0
    load(2'd0, 8'h0F);
    load(2'd1, 8'hF0);
    run_instr(3'd2, 2'd0, 2'd0, 2'd1, 1'b0, 2'd0, 8'h00);
    chk("xnor_carry", 32'(carry), 0);
    run_instr(3'd4, 2'd2, 2'd0, 2'd0, 1'b0, 2'd0, 8'h00);
    chk("xnor_r0", 32'(alu_op1), 32'h00);

    // load and handshake in the same cycle
    run_instr(3'd4, 2'd3, 2'd1, 2'd0, 1'b1, 2'd1, 8'h33);
    chk("samecyc_op1", 32'(alu_op1), 32'h33);
    run_instr(3'd5, 2'd0, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00);
    chk("samecyc_r3", 32'(alu_op2), 32'h33);

    // hold valid and ld_en high across a whole instruction
    bus.instr_valid = 1'b1;
    bus.instr       = {3'd0, 2'd1, 2'd0, 2'd0};
    bus.ld_en       = 1'b1;
    bus.ld_addr     = 2'd0;
    bus.ld_data     = 8'h55;
    step();
    m_rf[0] = 8'h55;
    bus.ld_addr = 2'd2;
    bus.ld_data = 8'hAA;
    lowc = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.instr_ready) break;
      lowc++;
      step();
    end
    bus.instr_valid = 1'b0;
    bus.ld_en       = 1'b0;
    chk("ready_low_cycles", 32'(lowc), 3);
    m_rf[1] = 8'hAA;
    m_cnt   = m_cnt + 8'd1;
    m_carry = 1'b0;
    m_res   = 8'hAA;
    chk("held_cnt", 32'(instr_cnt), 32'(m_cnt));
    chk("held_result", 32'(result), 32'hAA);
    run_instr(3'd4, 2'd3, 2'd2, 2'd1, 1'b0, 2'd0, 8'h00);
    chk("held_r2", 32'(alu_op1), 32'(m_rf[2]));

    // randomized instructions against the model
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1)
        load(2'($urandom_range(0, 3)), 8'($urandom));
      run_instr(3'($urandom_range(0, 7)),
                2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)),
                8'($urandom));
    end

    // reset during EXEC aborts the instruction
    do_reset();
    load(2'd0, 8'h90);
    bus.instr_valid = 1'b1;
    bus.instr       = {3'd0, 2'd1, 2'd0, 2'd0};
    step();
    bus.instr_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_rf[i] = '0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    step();
    chk("abort_done2", 32'(done), 0);
    chk("abort_carry", 32'(carry), 0);
    chk("abort_cnt", 32'(instr_cnt), 0);
    run_instr(3'd4, 2'd2, 2'd1, 2'd0, 1'b0, 2'd0, 8'h00);
    chk("abort_r1", 32'(alu_op1), 0);

    // 256 back-to-back instructions wrap the counter
    dcount = 0;
    wide   = 0;
    pd     = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = {3'd0, 2'd3, 2'd2, 2'd1};
    for (int c = 0; c < 1024; c++) begin
      step();
      if (done) begin
        dcount++;
        if (pd) wide++;
      end
      pd = done;
    end
    bus.instr_valid = 1'b0;
    chk("b2b_done_count", 32'(dcount), 256);
    chk("b2b_wide_pulses", 32'(wide), 0);
    chk("b2b_cnt_wrap", 32'(instr_cnt), 32'(m_cnt));
    step();
    chk("b2b_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 Parameters: none; datapath width fixed at 8 bits, register file fixed at 4 x 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr  input  9  [8:6] opcode (= ALU sel), [5:4] rd, [3:2] rs1, [1:0] rs2.
REQ-006 instr_ready  output  1  controller accepts instruction/load this cycle.
REQ-007 ld_en  input  1  host register-file write request.
REQ-008 ld_addr  input  2  host write address.
REQ-009 ld_data  input  8  host write data.
REQ-010 alu_op1  output  8  registered ALU operand 1.
REQ-011 alu_op2  output  8  registered ALU operand 2.
REQ-012 alu_sel  output  3  registered ALU function select.
REQ-013 alu_out  input  8  combinational ALU result.
REQ-014 alu_co  input  1  combinational ALU carry/flag.
REQ-015 done  output  1  one-cycle pulse: result written back.
REQ-016 result  output  8  last written-back value; valid when done=1, held otherwise.
REQ-017 carry  output  1  carry flag from last completed instruction.
REQ-018 busy  output  1  high in any state other than IDLE.
REQ-019 instr_cnt  output  8  completed-instruction counter.

Function
REQ-020 FSM states: IDLE, READ, EXEC, WRITE; no other reachable states.
REQ-021 instr_ready SHALL equal (state==IDLE) && !rst, combinationally.
REQ-022 IDLE: instr_valid && instr_ready -> latch instr, go READ; else stay IDLE.
REQ-023 READ: alu_op1<=R[rs1], alu_op2<=R[rs2], alu_sel<=opcode at cycle end; go EXEC.
REQ-024 EXEC: capture alu_out and alu_co into internal result/flag registers at cycle end; go WRITE.
REQ-025 WRITE: done=1, result shows captured value; at cycle end R[rd]<=captured value, carry<=captured flag, instr_cnt+=1; go IDLE.
REQ-026 Latency: handshake at edge T0 -> done high in cycle T2..T3 -> R[rd] updated at edge T3; throughput one instruction per 4 cycles.
REQ-027 alu_op1/op2/sel SHALL hold their values outside READ updates (stable from EXEC through next READ).
REQ-028 Opcodes are not interpreted; all 8 values (incl. pass-through 100/101/111) follow identical sequencing.
REQ-029 ld_en accepted only when instr_ready=1: R[ld_addr]<=ld_data at cycle end; ld_en otherwise ignored, no effect.
REQ-030 ld_en and instruction handshake in same cycle: both accepted; READ sees the loaded value.
REQ-031 rs1==rs2, rd==rs1 or rd==rs2 legal; READ uses pre-writeback values.
REQ-032 instr_cnt wraps 0xFF -> 0x00.
REQ-033 instr_valid ignored while busy; no queuing.

Reset
REQ-034 rst=1 at an edge: state<=IDLE, R[0..3]<=0, alu_op1/op2<=0, alu_sel<=000, result<=0, carry<=0, instr_cnt<=0, done<=0.
REQ-035 rst during READ/EXEC/WRITE aborts: no register-file write, no counter increment, no done pulse.
REQ-036 rst has priority over ld_en and instruction handshake in the same cycle.

Verification
REQ-037 Load R0=0x80, R1=0x80; instr ADD(000) rd=2 rs1=0 rs2=1 with ALU model -> alu_sel=000, op1=op2=0x80; done 2 cycles after handshake, result=0x00, carry=1, R2=0x00, instr_cnt=1.
REQ-038 Load R0=0x0F, R1=0xF0; XNOR(010) rd=0 rs1=0 rs2=1 -> result=0x00, carry=0, R0=0x00 after done; subsequent READ of R0 gives 0x00.
REQ-039 Same-cycle ld_en(addr1, 0x33) with instr pass(100) rd=3 rs1=1 -> alu_op1=0x33, R3=0x33.
REQ-040 instr_valid and ld_en held high while busy -> only first instruction accepted; R unchanged by ld until IDLE; instr_ready low for exactly 3 cycles.
REQ-041 rst asserted in EXEC -> next cycle IDLE, no done, rd register and carry unchanged (0), instr_cnt=0.
REQ-042 256 back-to-back instructions -> instr_cnt wraps to 0x00; done pulses exactly 256 times, each one cycle wide.
